// File: rtl/mdec_pixel_packer_pkg.sv
// mdec_pixel_packer_pkg: shared MDEC pixel depth/sign types, block sizes and pixel formatting helpers
package mdec_pixel_packer_pkg;
  typedef enum logic [1:0] {TPIX_4 = 2'd0, TPIX_8 = 2'd1, TPIX_24 = 2'd2, TPIX_15 = 2'd3} MDEC_TPIX;
  typedef enum logic {SIGN_UNSIGNED = 1'b0, SIGN_SIGNED = 1'b1} MDEC_SIGN;
  typedef enum logic [1:0] {BANK_FREE, BANK_FILLING, BANK_FULL, BANK_DRAINING} bankState_e;
  localparam int BLK8_PIXELS = 64;
  localparam int BLK16_PIXELS = 256;
  function automatic logic [8:0] blockTarget(input MDEC_TPIX d);
    return (d == TPIX_4 || d == TPIX_8) ? 9'(BLK8_PIXELS) : 9'(BLK16_PIXELS);
  endfunction
  function automatic logic [4:0] pixelWidth(input MDEC_TPIX d);
    return d == TPIX_4 ? 5'd4 : d == TPIX_8 ? 5'd8 : d == TPIX_15 ? 5'd16 : 5'd24;
  endfunction
  function automatic logic [23:0] formatPixel(input MDEC_TPIX d, input logic bit15, input logic [23:0] bgr);
    return d == TPIX_4 ? {20'd0, bgr[7:4]} :
           d == TPIX_8 ? {16'd0, bgr[7:0]} :
           d == TPIX_15 ? {8'd0, bit15, bgr[23:19], bgr[15:11], bgr[7:3]} : bgr;
  endfunction
endpackage

// File: rtl/mdec_pix_word_packer.sv
// mdec_pix_word_packer: little-endian shift accumulator turning 4/8/16/24-bit pixels into 32-bit words
module mdec_pix_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixValid,
  input  logic        pixLast,
  input  logic [23:0] pixData,
  input  logic [4:0]  pixWidth,
  output logic        pixReady,
  output logic        wordValid,
  output logic [31:0] word,
  output logic        lastWord,
  input  logic        wordReady
);
  logic [63:0] acc;
  logic [6:0] cnt;
  logic lastIn, take, load, lastNew;
  logic [87:0] accNew;
  logic [7:0] cntNew;
  // a word may be peeled off in the same cycle the pixel lands, so the merge is wider than acc
  always_comb begin
    pixReady = !(cnt >= 7'd32 && wordValid && !wordReady);
    take = pixValid && pixReady;
    accNew = {24'd0, acc} | (take ? {64'd0, pixData} << cnt : 88'd0);
    cntNew = {1'b0, cnt} + (take ? {3'd0, pixWidth} : 8'd0);
    lastNew = lastIn || (take && pixLast);
    load = cntNew >= 8'd32 && (!wordValid || wordReady);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      lastIn <= 1'b0;
      wordValid <= 1'b0;
      word <= '0;
      lastWord <= 1'b0;
    end else begin
      acc <= load ? {8'd0, accNew[87:32]} : accNew[63:0];
      cnt <= load ? 7'(cntNew - 8'd32) : cntNew[6:0];
      lastIn <= lastNew && !(load && cntNew == 8'd32);
      if (load) begin
        word <= accNew[31:0];
        wordValid <= 1'b1;
        lastWord <= lastNew && cntNew == 8'd32;
      end else if (wordReady) begin
        wordValid <= 1'b0;
        lastWord <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/mdec_pixel_packer.sv
// mdec_pixel_packer: ping-pong macroblock banks reordered to raster and packed into 32-bit output words
module mdec_pixel_packer
  import mdec_pixel_packer_pkg::*;
#(
  parameter int STOP_MARGIN = 8
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic [1:0]  i_bitSetupDepth,
  input  logic        i_bit15,
  input  logic        i_pixelOut,
  input  logic [7:0]  i_pixelAddress,
  input  logic [7:0]  i_rComp,
  input  logic [7:0]  i_gComp,
  input  logic [7:0]  i_bComp,
  output logic        o_stopFillY,
  output logic        o_wordValid,
  output logic [31:0] o_word,
  output logic        o_lastWord,
  input  logic        i_wordReady,
  output logic        o_overflow,
  output logic        o_busy
);
  localparam logic [8:0] MARGIN = 9'(STOP_MARGIN);
  bankState_e bankState [2];
  bankState_e nState [2];
  logic [8:0] fillCnt [2];
  logic [8:0] nCnt [2];
  MDEC_TPIX tag [2];
  MDEC_TPIX nTag [2];
  logic [23:0] mem0 [256];
  logic [23:0] mem1 [256];
  logic fillPtr, nPtr, drainBank, wb, startBank;
  logic drainActive, drainStart, drainDone, otherFree, dropPix, wrEn;
  logic rdActive, pValid, pLast, issue, pixReady;
  logic [7:0] idx, rdAddr;
  logic [23:0] rdData;
  logic [8:0] drainTgt;
  MDEC_TPIX drainTag;
  // a full fill bank hands the pointer over as soon as the other bank is (or is becoming) free
  always_comb begin
    drainActive = bankState[0] == BANK_DRAINING || bankState[1] == BANK_DRAINING;
    drainDone = o_wordValid && o_lastWord && i_wordReady;
    startBank = bankState[!fillPtr] == BANK_FULL ? !fillPtr : fillPtr;
    drainStart = !drainActive && bankState[startBank] == BANK_FULL;
    otherFree = bankState[!fillPtr] == BANK_FREE || (drainDone && drainBank != fillPtr);
    wb = (bankState[fillPtr] == BANK_FULL && otherFree) ? !fillPtr : fillPtr;
    dropPix = i_pixelOut && bankState[wb] == BANK_FULL;
    wrEn = i_pixelOut && !dropPix;
    for (int b = 0; b < 2; b++) begin
      nState[b] = bankState[b];
      nCnt[b] = fillCnt[b];
      nTag[b] = tag[b];
      if (drainStart && startBank == 1'(b)) nState[b] = BANK_DRAINING;
      if (drainDone && drainBank == 1'(b)) begin
        nState[b] = BANK_FREE;
        nCnt[b] = '0;
      end
      if (wrEn && wb == 1'(b)) begin
        if (nState[b] == BANK_FREE) nTag[b] = MDEC_TPIX'(i_bitSetupDepth);
        nCnt[b] = nCnt[b] + 9'd1;
        nState[b] = nCnt[b] == blockTarget(nTag[b]) ? BANK_FULL : BANK_FILLING;
      end
    end
    nPtr = (nState[wb] == BANK_FULL && nState[!wb] == BANK_FREE) ? !wb : wb;
    drainTag = tag[drainBank];
    drainTgt = blockTarget(drainTag);
    rdAddr = drainTgt == 9'(BLK8_PIXELS) ? {1'b0, idx[5:3], 1'b0, idx[2:0]} : idx;
    issue = rdActive && (!pValid || pixReady);
    o_stopFillY = (fillCnt[fillPtr] >= blockTarget(tag[fillPtr]) - MARGIN || bankState[fillPtr] == BANK_FULL)
                  && bankState[!fillPtr] != BANK_FREE;
    o_busy = bankState[0] != BANK_FREE || bankState[1] != BANK_FREE || o_wordValid;
  end
  always_ff @(posedge clk) begin
    if (i_rst) begin
      bankState <= '{BANK_FREE, BANK_FREE};
      fillCnt <= '{9'd0, 9'd0};
      tag <= '{TPIX_4, TPIX_4};
      fillPtr <= 1'b0;
      drainBank <= 1'b0;
      o_overflow <= 1'b0;
      rdActive <= 1'b0;
      idx <= '0;
      pValid <= 1'b0;
      pLast <= 1'b0;
    end else begin
      bankState <= nState;
      fillCnt <= nCnt;
      tag <= nTag;
      fillPtr <= nPtr;
      o_overflow <= o_overflow | dropPix;
      if (drainStart) begin
        drainBank <= startBank;
        rdActive <= 1'b1;
        idx <= '0;
      end else if (issue) begin
        idx <= idx + 8'd1;
        rdActive <= {1'b0, idx} != drainTgt - 9'd1;
      end
      if (issue) begin
        pValid <= 1'b1;
        pLast <= {1'b0, idx} == drainTgt - 9'd1;
      end else if (pixReady) pValid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wrEn && !wb) mem0[i_pixelAddress] <= {i_bComp, i_gComp, i_rComp};
    if (wrEn && wb) mem1[i_pixelAddress] <= {i_bComp, i_gComp, i_rComp};
    if (issue) rdData <= drainBank ? mem1[rdAddr] : mem0[rdAddr];
  end
  mdec_pix_word_packer packer (
    .clk(clk),
    .rst(i_rst),
    .pixValid(pValid),
    .pixLast(pLast),
    .pixData(formatPixel(drainTag, i_bit15, rdData)),
    .pixWidth(pixelWidth(drainTag)),
    .pixReady(pixReady),
    .wordValid(o_wordValid),
    .word(o_word),
    .lastWord(o_lastWord),
    .wordReady(i_wordReady)
  );
endmodule
